// File: rtl/usb_link_pkg.sv
// Shared link constants and receive FSM encoding, common to the transmit and receive chains.
package usb_link_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned RUN_LEN_DEF = 6;
  localparam logic        LINE_IDLE   = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

endpackage

// File: rtl/rx_nrzi_unstuff_sipo_nrzi_dec.sv
// NRZI decoder: line reference register plus the "no transition means 1" compare.
module nrzi_dec
  import usb_link_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic dbit_c
);

  logic line_q, line_d;

  assign dbit_c = (din == line_q);

  always_comb begin
    line_d = line_q;
    if (clr)     line_d = LINE_IDLE;
    else if (en) line_d = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) line_q <= LINE_IDLE;
    else      line_q <= line_d;
  end

endmodule

// File: rtl/rx_nrzi_unstuff_sipo.sv
// Receive front end: NRZI decode, zero unstuffing and LSB-first deserialisation into words.
// Optional stuff-violation detection is enabled by defining RX_STUFF_ERR_EN.
module rx_nrzi_unstuff_sipo
  import usb_link_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RUN_LEN = RUN_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              stuff_err
);

  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned ONES_W = $clog2(RUN_LEN + 1);

  logic [1:0]        state_q, state_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              consume_c;
  logic              do_shift;
  logic              dbit_c;

  // ERR freezes the line reference too, so realignment only happens through clr.
  assign consume_c = en && (state_q != ST_ERR);

  nrzi_dec u_nrzi_dec (
    .clk    (clk),
    .rst    (rst),
    .en     (consume_c),
    .clr    (clr),
    .din    (din),
    .dbit_c (dbit_c)
  );

`ifdef RX_STUFF_ERR_EN
  logic stuff_err_q, stuff_err_d;
  assign stuff_err = stuff_err_q;
`else
  assign stuff_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    do_shift     = 1'b0;
`ifdef RX_STUFF_ERR_EN
    stuff_err_d  = stuff_err_q;
`endif
    if (clr) begin
      state_d   = ST_IDLE;
      ones_d    = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
`ifdef RX_STUFF_ERR_EN
      stuff_err_d = 1'b0;
`endif
    end else if (consume_c) begin
      state_d = ST_SHIFT;
      if (ones_q == ONES_W'(RUN_LEN)) begin
        // Stuff slot: a 0 here is the inserted bit and never reaches the word.
        if (!dbit_c) begin
          ones_d = '0;
        end else begin
`ifdef RX_STUFF_ERR_EN
          stuff_err_d = 1'b1;
          state_d     = ST_ERR;
          ones_d      = '0;
          bit_cnt_d   = '0;
          shift_d     = '0;
`else
          ones_d   = ONES_W'(1);
          do_shift = 1'b1;
`endif
        end
      end else begin
        ones_d   = dbit_c ? (ones_q + ONES_W'(1)) : '0;
        do_shift = 1'b1;
      end
      if (do_shift) begin
        shift_d[bit_cnt_q] = dbit_c;
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          dout_d       = shift_d;
          dout_valid_d = 1'b1;
          bit_cnt_d    = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ones_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef RX_STUFF_ERR_EN
      stuff_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ones_q       <= ones_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef RX_STUFF_ERR_EN
      stuff_err_q  <= stuff_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_rx_nrzi_unstuff_sipo.sv
// Scoreboard bench for rx_nrzi_unstuff_sipo: decoded bits are NRZI-encoded here, expected words queued.
module tb_rx_nrzi_unstuff_sipo;

  typedef struct {
    logic [7:0] word;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic       din = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       stuff_err;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic line   = 1'b1;

  rx_nrzi_unstuff_sipo #(.DATA_W(8), .RUN_LEN(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .stuff_err  (stuff_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest queued word and arrive on its expected cycle.
  always @(negedge clk) begin
    if (dout_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_strobe: dout=%h at cycle %0d, no word expected", dout, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dout !== e.word || cyc != e.cyc) begin
          n_miss++;
          $display("FAIL word: got dout=%h at cycle %0d, expected %h at cycle %0d",
                   dout, cyc, e.word, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one decoded bit as its NRZI line level.
  task automatic drive_bit(input logic b);
    @(negedge clk);
    din = b ? line : ~line;
    line = din;
    en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  // Call right after the last bit is driven: the strobe follows its sample edge.
  task automatic expect_word(input logic [7:0] w);
    exp_t e;
    e.word = w;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive_bit(w[i]);
    expect_word(w);
  endtask

  task automatic clr_pulse(input logic with_en);
    @(negedge clk);
    clr = 1'b1;
    en  = with_en;
    din = ~din;
    @(negedge clk);
    clr  = 1'b0;
    en   = 1'b0;
    line = 1'b1;
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    // Reset state, sampled while reset is asserted
    #3;
    check("rst_dout", dout, 8'h00);
    check("rst_valid", {7'd0, dout_valid}, 8'h00);
    check("rst_stuff_err", {7'd0, stuff_err}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // 1: plain byte
    send_byte(8'hA5);
    idle(3);
    check("t1_stuff_err", {7'd0, stuff_err}, 8'h00);

    // 2: six ones, stuffed zero, two ones -> 0xFF
    clr_pulse(1'b0);
    for (int i = 0; i < 6; i++) drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    expect_word(8'hFF);
    idle(3);

    // 3: seven decoded ones in a row
    clr_pulse(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(1'b1);
    drive_bit(1'b1);
`ifndef RX_STUFF_ERR_EN
    expect_word(8'hFF);
`endif
    idle(3);
`ifdef RX_STUFF_ERR_EN
    check("t3_stuff_err_set", {7'd0, stuff_err}, 8'h01);
`else
    check("t3_stuff_err_off", {7'd0, stuff_err}, 8'h00);
`endif
    clr_pulse(1'b0);
    check("t3_stuff_err_clr", {7'd0, stuff_err}, 8'h00);
    send_byte(8'hA5);
    idle(3);

    // 4: enable gaps mid-word and inside the stuff slot
    clr_pulse(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(a5[i]);
    idle(5);
    for (int i = 4; i < 8; i++) drive_bit(a5[i]);
    expect_word(8'hA5);
    idle(3);
    clr_pulse(1'b0);
    for (int i = 0; i < 6; i++) drive_bit(1'b1);
    idle(5);
    drive_bit(1'b0);
    idle(2);
    drive_bit(1'b1);
    drive_bit(1'b1);
    expect_word(8'hFF);
    idle(3);

    // 5: asynchronous reset after five bits of a word
    clr_pulse(1'b0);
    send_byte(8'hA5);
    idle(2);
    for (int i = 0; i < 5; i++) drive_bit(a5[i]);
    idle(1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_dout", dout, 8'h00);
    check("t5_rst_valid", {7'd0, dout_valid}, 8'h00);
    check("t5_rst_stuff_err", {7'd0, stuff_err}, 8'h00);
    @(negedge clk);
    rst  = 1'b1;
    line = 1'b1;
    send_byte(8'hA5);
    idle(3);

    // 6: clr together with en mid-word discards the partial word
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    clr_pulse(1'b1);
    check("t6_dout_kept", dout, 8'hA5);
    send_byte(8'h3C);
    idle(4);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL missing_strobes: %0d words still expected, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
